// File: rtl/sys_pkg.sv
// Shared definitions for the FIFO read-side drain: state encoding and default word width.
package sys_pkg;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_WAIT_HI = 2'b01;
  localparam logic [1:0] S_WAIT_LO = 2'b10;

  localparam int D_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    WAIT_HI = S_WAIT_HI,
    WAIT_LO = S_WAIT_LO
  } drain_state_t;

endpackage

// File: rtl/fifo_rd_drain.sv
// Pops one word from the async FIFO read port and hands it to UART TX over a valid/busy handshake.
// Optional busy-rise timeout enabled by defining FIFO_DRAIN_TIMEOUT_EN.
module fifo_rd_drain
  import sys_pkg::*;
#(
  parameter int D_SIZE    = D_SIZE_DEF,
  parameter int TO_CYCLES = 32,
  parameter int TO_W      = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_empty,
  input  logic [D_SIZE-1:0] i_rd_data,
  output logic              o_rd_inc,
  input  logic              i_tx_busy,
  output logic [D_SIZE-1:0] o_tx_data,
  output logic              o_tx_valid,
  output logic              o_active,
  output logic              o_timeout
);

  drain_state_t state;

  if (2 ** TO_W <= TO_CYCLES) begin : g_bad_cfg
    $error("fifo_rd_drain: TO_W too narrow for TO_CYCLES");
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  // Capture and pop share edge E; the FIFO pointer moves at E+1, and IDLE is
  // revisited no earlier than E+3, so the empty flag is already up to date.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      o_rd_inc   <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_active   <= 1'b0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
      o_timeout  <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      o_rd_inc   <= 1'b0;
      o_tx_valid <= 1'b0;
`ifdef FIFO_DRAIN_TIMEOUT_EN
      o_timeout  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!i_empty && !i_tx_busy) begin
            o_tx_data  <= i_rd_data;
            o_rd_inc   <= 1'b1;
            o_tx_valid <= 1'b1;
            o_active   <= 1'b1;
            state      <= WAIT_HI;
`ifdef FIFO_DRAIN_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        WAIT_HI: begin
          if (i_tx_busy) begin
            state <= WAIT_LO;
          end
`ifdef FIFO_DRAIN_TIMEOUT_EN
          else if (to_cnt == TO_W'(TO_CYCLES - 1)) begin
            // Transmitter never acknowledged: drop the word and go back to polling.
            state     <= IDLE;
            o_active  <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WAIT_LO: begin
          if (!i_tx_busy) begin
            state    <= IDLE;
            o_active <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          o_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Randomized bench for fifo_rd_drain: FIFO queue and TX responder models drive the DUT,
// a transaction-level reference predicts every output each cycle.
module tb_fifo_rd_drain;

  localparam int D_SIZE    = 8;
  localparam int TO_CYCLES = 32;
  localparam int TO_W      = 6;

  logic              CLK = 1'b0;
  logic              RST;
  logic              i_empty;
  logic [D_SIZE-1:0] i_rd_data;
  logic              o_rd_inc;
  logic              i_tx_busy;
  logic [D_SIZE-1:0] o_tx_data;
  logic              o_tx_valid;
  logic              o_active;
  logic              o_timeout;

  fifo_rd_drain #(.D_SIZE(D_SIZE), .TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) dut (
    .CLK(CLK), .RST(RST), .i_empty(i_empty), .i_rd_data(i_rd_data), .o_rd_inc(o_rd_inc),
    .i_tx_busy(i_tx_busy), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .o_active(o_active), .o_timeout(o_timeout)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a word is "held" from hand-off until TX has gone busy and idle again.
  bit              m_hold, m_saw_busy, m_rd_inc, m_valid, m_to;
  int              m_wait;
  logic [D_SIZE-1:0] m_data;

  logic [D_SIZE-1:0] q[$];
  logic [D_SIZE-1:0] seen[$];
  bit pop_pend, tx_mute, force_busy;
  int tx_cd = -1, tx_rem = 0, tx_dly = 0, tx_len = 3;
  int pops = 0, cyc = 0, valid_cyc = 0, to_cyc = 0;

  task automatic model_clear();
    m_hold = 0; m_saw_busy = 0; m_rd_inc = 0; m_valid = 0; m_to = 0; m_wait = 0;
    m_data = '0;
    pop_pend = 0; tx_cd = -1; tx_rem = 0;
  endtask

  task automatic model_step();
    m_rd_inc = 0; m_valid = 0; m_to = 0;
    if (!m_hold) begin
      if (!i_empty && !i_tx_busy) begin
        m_data = i_rd_data; m_rd_inc = 1; m_valid = 1;
        m_hold = 1; m_saw_busy = 0; m_wait = 0;
      end
    end else if (!m_saw_busy) begin
      if (i_tx_busy) m_saw_busy = 1;
      else begin
        m_wait++;
`ifdef FIFO_DRAIN_TIMEOUT_EN
        if (m_wait == TO_CYCLES) begin
          m_hold = 0; m_to = 1;
        end
`endif
      end
    end else if (!i_tx_busy) begin
      m_hold = 0;
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    if (pop_pend && q.size() > 0) void'(q.pop_front());
    pop_pend = m_rd_inc;
    if (m_valid && !tx_mute) tx_cd = tx_dly;
    if (tx_rem > 0) begin
      i_tx_busy = 1'b1; tx_rem--;
    end else if (tx_cd == 0) begin
      i_tx_busy = 1'b1; tx_rem = tx_len - 1; tx_cd = -1;
    end else begin
      i_tx_busy = 1'b0;
      if (tx_cd > 0) tx_cd--;
    end
    if (force_busy) i_tx_busy = 1'b1;
    i_empty   = (q.size() == 0);
    i_rd_data = i_empty ? '0 : q[0];
    @(posedge CLK);
    model_step();
    cyc++;
    #1;
    chk("rd_inc",   32'(o_rd_inc),   32'(m_rd_inc));
    chk("tx_valid", 32'(o_tx_valid), 32'(m_valid));
    chk("tx_data",  32'(o_tx_data),  32'(m_data));
    chk("active",   32'(o_active),   32'(m_hold));
    chk("timeout",  32'(o_timeout),  32'(m_to));
    if (o_rd_inc) pops++;
    if (o_tx_valid) begin
      seen.push_back(o_tx_data);
      valid_cyc = cyc;
    end
    if (o_timeout) to_cyc = cyc;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_inc"},   32'(o_rd_inc),   0);
    chk({tag, "_tx_valid"}, 32'(o_tx_valid), 0);
    chk({tag, "_tx_data"},  32'(o_tx_data),  0);
    chk({tag, "_active"},   32'(o_active),   0);
    chk({tag, "_timeout"},  32'(o_timeout),  0);
  endtask

  initial begin
    logic [D_SIZE-1:0] burst [4];
    int n;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44};
    RST = 1'b0; i_empty = 1'b1; i_rd_data = '0; i_tx_busy = 1'b0;
    tx_mute = 0; force_busy = 0;
    model_clear();
    #12;
    check_all_zero("reset");
    @(negedge CLK); RST = 1'b1;

    // Empty FIFO for 100 clocks
    run(100);
    chk("empty_pops", pops, 0);

    // Single word
    tx_dly = 0; tx_len = 10;
    q.push_back(8'hA5);
    run(20);
    chk("single_pops", pops, 1);
    chk("single_data", 32'(seen[0]), 32'hA5);
    chk("single_idle", 32'(o_active), 0);

    // Burst of four
    pops = 0; seen.delete();
    tx_dly = 1; tx_len = 4;
    foreach (burst[i]) q.push_back(burst[i]);
    run(40);
    chk("burst_pops", pops, 4);
    for (int i = 0; i < 4; i++)
      chk("burst_order", (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD, 32'(burst[i]));

    // Busy preset before data arrives
    pops = 0;
    force_busy = 1;
    q.push_back(8'h5A);
    run(6);
    chk("preset_nopop", pops, 0);
    force_busy = 0;
    run(15);
    chk("preset_pop", pops, 1);

    // Reset while in WAIT_LO
    pops = 0;
    tx_dly = 0; tx_len = 10;
    q.push_back(8'h3C);
    n = 0;
    while (!(m_hold && m_saw_busy) && n < 10) begin
      tick(); n++;
    end
    chk("reach_wait_lo", 32'(m_hold && m_saw_busy), 1);
    @(negedge CLK); #2;
    RST = 1'b0;
    #1;
    check_all_zero("midreset");
    model_clear();
    q.delete();
    i_empty = 1'b1; i_tx_busy = 1'b0;
    @(negedge CLK); RST = 1'b1;
    pops = 0;
    run(10);
    chk("post_reset_pops", pops, 0);

    // Transmitter never responds
    tx_mute = 1;
    q.push_back(8'h77);
    run(40);
`ifdef FIFO_DRAIN_TIMEOUT_EN
    chk("timeout_gap", to_cyc - valid_cyc, TO_CYCLES);
    chk("timeout_idle", 32'(o_active), 0);
`else
    chk("no_timeout_active", 32'(o_active), 1);
    force_busy = 1;
    run(2);
    force_busy = 0;
    run(3);
    chk("recovered_idle", 32'(o_active), 0);
`endif
    tx_mute = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && q.size() < 8) q.push_back(D_SIZE'($urandom));
      tx_dly = $urandom_range(0, 3);
      tx_len = $urandom_range(1, 8);
      force_busy = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer for the async FIFO. Runs in the FIFO read clock domain.
- Pops one word at a time whenever the FIFO is non-empty and hands it to the UART transmitter over a valid/busy handshake.
- Waits for the transmitter to finish before popping again, so no word is lost or duplicated.
- Sits between the async FIFO read port and the UART TX data input.

Parameters:
- D_SIZE, 8, data word width; matches the FIFO data width.
- TO_CYCLES, 32, busy-rise timeout in clocks; used only with FIFO_DRAIN_TIMEOUT_EN.
- TO_W, 6, width of the timeout counter; must satisfy 2^TO_W > TO_CYCLES.

Ports:
- CLK, input, 1: read-domain clock (same clock as the FIFO read side and UART TX).
- RST, input, 1: reset, asynchronous, active-low.
- i_empty, input, 1: FIFO empty flag (read domain).
- i_rd_data, input, D_SIZE: FIFO read data at the current read address; combinational, valid while i_empty=0.
- o_rd_inc, output, 1: FIFO read-increment; one-cycle pulse per pop.
- i_tx_busy, input, 1: UART TX busy; high for the whole frame.
- o_tx_data, output, D_SIZE: registered data word to TX.
- o_tx_valid, output, 1: one-cycle data-valid pulse to TX.
- o_active, output, 1: high whenever state is not IDLE.
- o_timeout, output, 1: one-cycle timeout pulse; tied 0 without the macro.

Behaviour:
- All outputs are registered. Reset (RST=0, asynchronous) forces:
  - state=IDLE, o_rd_inc=0, o_tx_valid=0, o_tx_data=0, o_active=0, o_timeout=0, timeout counter=0.
- States: IDLE, WAIT_HI, WAIT_LO.
- IDLE:
  - If i_empty=0 and i_tx_busy=0 at edge E:
    - o_tx_data<=i_rd_data, o_rd_inc<=1, o_tx_valid<=1, state<=WAIT_HI.
    - o_rd_inc and o_tx_valid are high for exactly one cycle after E.
  - Otherwise remain in IDLE with both pulses 0.
- WAIT_HI:
  - i_tx_busy=1 -> WAIT_LO.
  - Otherwise stay.
- WAIT_LO:
  - i_tx_busy=0 -> IDLE.
  - Otherwise stay.
- Capture and pop happen on the same edge. Data is sampled before the FIFO pointer advances (the FIFO sees o_rd_inc at E+1).
- Minimum IDLE-to-IDLE cycle is 3 clocks. i_empty is re-sampled no earlier than E+3, after the FIFO read pointer and empty flag have updated. No extra guard state is needed.
- Back-to-back words: after returning to IDLE with i_empty=0, the next pop occurs on the next edge. There is no idle bubble beyond the handshake.
- i_tx_busy=1 already in IDLE: no pop until busy drops.
- i_empty asserting while in WAIT_*: no effect; only IDLE samples it.
- Reset mid-operation: the popped word is discarded. o_rd_inc drops immediately, so no partial or double pop occurs.
- o_tx_data holds its value until the next capture.

Optional Feature:
- Macro: FIFO_DRAIN_TIMEOUT_EN.
- With the macro:
  - TO_W-bit counter clears on entry to WAIT_HI and increments each cycle in WAIT_HI while i_tx_busy=0.
  - When it reaches TO_CYCLES-1 with busy still 0: state<=IDLE and o_timeout pulses for one cycle. The popped word is dropped.
  - The counter is unused in other states.
- Without the macro:
  - WAIT_HI waits indefinitely.
  - o_timeout is constant 0 and no counter logic is synthesized.

Decomposition:
- Shared package sys_pkg holds:
  - state encoding localparams (IDLE=2'b00, WAIT_HI=2'b01, WAIT_LO=2'b10);
  - the default D_SIZE.
- No sub-module: FSM, data register and timeout counter are inline in one module.

Test Plan:
- Single word: FIFO holds 0xA5, TX idle, busy rises 1 clk after valid and stays high 10 clks -> exactly one o_rd_inc and one o_tx_valid with o_tx_data=0xA5; o_active falls 1 clk after busy falls.
- Burst: 4 words 0x11,0x22,0x33,0x44 queued -> 4 pops in order, each valid only after the previous busy fall, never two o_rd_inc without an intervening busy pulse.
- Busy preset: i_tx_busy=1 while FIFO becomes non-empty -> no pop until busy=0; then pop on the next edge.
- Reset mid-transfer: assert RST in WAIT_LO -> all outputs 0 immediately; after release with FIFO empty, no o_rd_inc.
- Timeout (macro on, TO_CYCLES=32): busy never rises -> o_timeout pulses once 32 clks after the valid pulse and state returns to IDLE. With the macro off: stays in WAIT_HI and o_timeout=0.
- Empty FIFO: i_empty=1 for 100 clks -> o_rd_inc, o_tx_valid and o_active stay 0.
